// File: rtl/count_signals_pkg.sv
// count_signals_pkg
//  Shared types and helpers for the count_signals_arbiter block.
//  - state_t  : arbiter FSM states
//  - POPCNT_W : width of a 4-input popcount result (0..4)
//  - sat_add  : saturating add, clamped to an acc_w-bit maximum
package count_signals_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int POPCNT_W = 3;

    // The sum is formed one bit wider than the operands so an overflow past
    // the acc_w-bit maximum is always visible before clamping.
    function automatic logic [31:0] sat_add(
        input logic [31:0] acc,
        input logic [31:0] inc,
        input int unsigned acc_w
    );
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, acc} + {1'b0, inc};
        max_val = (33'd1 << acc_w) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/count_signals_arbiter_popcount4.sv
// popcount4
//  Purely combinational count of set bits in a 4-bit word.
//  Ports:
//   bits  in  [3:0]           word to count
//   count out [POPCNT_W-1:0]  number of ones (0..4)
module popcount4
    import count_signals_pkg::*;
(
    input  logic [3:0]          bits,
    output logic [POPCNT_W-1:0] count
);

    assign count = POPCNT_W'(bits[0]) + POPCNT_W'(bits[1])
                 + POPCNT_W'(bits[2]) + POPCNT_W'(bits[3]);

endmodule

// File: rtl/count_signals_arbiter.sv
// count_signals_arbiter
//  Round-robin arbiter sharing one popcount4 datapath among N_REQ requesters.
//  A granted requester streams 4-bit beats until 'last'; the popcounts of all
//  beats are summed (saturating) into one packet total, returned with the
//  owner's id over a registered valid/ready result port.
//  Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req[N_REQ]    per-requester beat valid
//   last[N_REQ]   per-requester final-beat flag (qualified by req)
//   data[4*N_REQ] per-requester beat, requester i at [4i+3:4i]
//   gnt[N_REQ]    one-hot grant, doubles as beat ready
//   result        saturated packet total
//   result_id     requester that owns result
//   result_valid  result/result_id valid
//   result_ready  consumer accepts result
//   busy          high whenever the FSM is not IDLE
module count_signals_arbiter
    import count_signals_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int ACC_W = 8,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ-1:0]   last,
    input  logic [4*N_REQ-1:0] data,
    output logic [N_REQ-1:0]   gnt,
    output logic [ACC_W-1:0]   result,
    output logic [ID_W-1:0]    result_id,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy
);

    state_t              state_reg, state_next;
    logic [N_REQ-1:0]    gnt_reg, gnt_next;
    logic [ID_W-1:0]     idx_reg, idx_next;
    logic [ACC_W-1:0]    acc_reg, acc_next;
    logic [ACC_W-1:0]    result_reg, result_next;
    logic [ID_W-1:0]     result_id_reg, result_id_next;
    logic                result_valid_reg, result_valid_next;
    logic [ID_W-1:0]     rr_ptr_reg, rr_ptr_next;

    // Split the flat data bus into lanes so the shared datapath can be fed
    // by a plain index mux on the registered grant index.
    logic [3:0] lanes [N_REQ];
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lanes[gi] = data[4*gi +: 4];
        end
    endgenerate

    logic [3:0]          beat_data;
    logic [POPCNT_W-1:0] pop_count;
    logic [ACC_W-1:0]    sum_sat;

    assign beat_data = lanes[idx_reg];

    popcount4 u_popcount4 (
        .bits  (beat_data),
        .count (pop_count)
    );

    assign sum_sat = ACC_W'(sat_add(32'(acc_reg), 32'(pop_count), ACC_W));

    // Round-robin pick: first requester with req set, scanning upward from
    // rr_ptr+1 with wrap, so the previous owner has lowest priority.
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!pick_found && req[(int'(rr_ptr_reg) + k) % N_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'((int'(rr_ptr_reg) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        gnt_next          = gnt_reg;
        idx_next          = idx_reg;
        acc_next          = acc_reg;
        result_next       = result_reg;
        result_id_next    = result_id_reg;
        result_valid_next = result_valid_reg;
        rr_ptr_next       = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    gnt_next   = N_REQ'(1) << pick_idx;
                    idx_next   = pick_idx;
                    acc_next   = '0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                // Only the granted lane is looked at; req low is a stall.
                if (req[idx_reg]) begin
                    acc_next = sum_sat;
                    if (last[idx_reg]) begin
                        result_next       = sum_sat;
                        result_id_next    = idx_reg;
                        gnt_next          = '0;
                        result_valid_next = 1'b1;
                        state_next        = DONE;
                    end
                end
            end
            DONE: begin
                if (result_ready) begin
                    result_valid_next = 1'b0;
                    rr_ptr_next       = result_id_reg;
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            gnt_reg          <= '0;
            idx_reg          <= '0;
            acc_reg          <= '0;
            result_reg       <= '0;
            result_id_reg    <= '0;
            result_valid_reg <= 1'b0;
            rr_ptr_reg       <= ID_W'(N_REQ - 1);
        end else begin
            state_reg        <= state_next;
            gnt_reg          <= gnt_next;
            idx_reg          <= idx_next;
            acc_reg          <= acc_next;
            result_reg       <= result_next;
            result_id_reg    <= result_id_next;
            result_valid_reg <= result_valid_next;
            rr_ptr_reg       <= rr_ptr_next;
        end
    end

    assign gnt          = gnt_reg;
    assign result       = result_reg;
    assign result_id    = result_id_reg;
    assign result_valid = result_valid_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_count_signals_arbiter.sv
module tb_count_signals_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance: N_REQ=4, ACC_W=8
    logic [3:0]  req, last;
    logic [15:0] data;
    logic        result_ready;
    logic [3:0]  gnt;
    logic [7:0]  result;
    logic [1:0]  result_id;
    logic        result_valid, busy;

    // Saturation instance: N_REQ=4, ACC_W=4
    logic [3:0]  req_s, last_s;
    logic [15:0] data_s;
    logic        ready_s;
    logic [3:0]  gnt_s;
    logic [3:0]  result_s;
    logic [1:0]  id_s;
    logic        valid_s, busy_s;

    count_signals_arbiter #(.N_REQ(4), .ACC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .data(data),
        .gnt(gnt), .result(result), .result_id(result_id),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
    );

    count_signals_arbiter #(.N_REQ(4), .ACC_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .req(req_s), .last(last_s), .data(data_s),
        .gnt(gnt_s), .result(result_s), .result_id(id_s),
        .result_valid(valid_s), .result_ready(ready_s), .busy(busy_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n);
        repeat (n) cyc();
    endtask

    // Random-phase stimulus and reference model storage
    int          nb   [4][3];
    logic [3:0]  pd   [4][3][8];
    int          eq_id[$];
    int          eq_sum[$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord [4];
        int pcs [4];
        int w;
        int rem [4];
        int used[4];
        int last_o, s, c;
        int pk[4], bt[4];
        int done_n, cycles;
        logic [3:0] g, r;

        rst_n = 1'b0; req = 4'b1111; last = '0; data = '0; result_ready = 1'b0;
        req_s = '0; last_s = '0; data_s = '0; ready_s = 1'b1;

        // 1: reset state, then requester 0 first
        cycn(3);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(result_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_id", 32'(result_id), 0);
        rst_n = 1'b1;
        cyc();
        chk("first_gnt_req0", 32'(gnt), 32'h1);
        chk("first_busy", 32'(busy), 1);
        req = 4'b0001; last = 4'b0001; data = 16'h0000; result_ready = 1'b1;
        cyc();
        req = '0; last = '0;
        chk("first_valid", 32'(result_valid), 1);
        chk("first_result", 32'(result), 0);
        cyc();
        chk("first_done_valid", 32'(result_valid), 0);
        chk("first_done_busy", 32'(busy), 0);
        $display("step reset/first grant done");

        // 2: single packet F,3,1 from requester 2 -> 7; 4a: backpressure
        result_ready = 1'b0;
        req = 4'b0100; data = 16'h0F00;
        cyc();
        chk("pkt_gnt2", 32'(gnt), 32'h4);
        cyc();
        data = 16'h0300;
        cyc();
        data = 16'h0100; last = 4'b0100;
        cyc();
        chk("pkt_valid", 32'(result_valid), 1);
        chk("pkt_result", 32'(result), 7);
        chk("pkt_id", 32'(result_id), 2);
        chk("pkt_gnt_clear", 32'(gnt), 0);
        req = '0; last = '0; data = 16'hxxxx;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_result", 32'(result), 7);
            chk("bp_valid", 32'(result_valid), 1);
            chk("bp_gnt", 32'(gnt), 0);
        end
        result_ready = 1'b1;
        cyc();
        chk("bp_release_valid", 32'(result_valid), 0);
        chk("bp_result_held", 32'(result), 7);
        $display("step single packet total=%0d id=%0d", result, result_id);

        // 3: round robin from reset, req=1011, one-beat packets
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        ord = '{0, 1, 3, 0};
        pcs = '{1, 2, 3, 1};
        req = 4'b1011; last = 4'b1111; data = 16'h7031;
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (gnt == 4'b0 && w < 10) begin
                cyc();
                w++;
            end
            chk("rr_gnt", 32'(gnt), 32'(1) << ord[k]);
            cyc();
            if (k == 3) begin
                req = '0; last = '0;
            end
            chk("rr_valid", 32'(result_valid), 1);
            chk("rr_id", 32'(result_id), 32'(ord[k]));
            chk("rr_result", 32'(result), 32'(pcs[k]));
            $display("rr grant id=%0d total=%0d", result_id, result);
        end
        cyc();

        // 4b: stall mid-packet for 3 cycles (last without req ignored)
        req = 4'b0010; data = 16'h00F0; last = '0;
        cyc();
        chk("stall_gnt", 32'(gnt), 32'h2);
        cyc();
        req = '0; last = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_gnt_held", 32'(gnt), 32'h2);
            chk("stall_no_valid", 32'(result_valid), 0);
        end
        req = 4'b0010; data = 16'h0010; last = 4'b0010;
        cyc();
        req = '0; last = '0;
        chk("stall_valid", 32'(result_valid), 1);
        chk("stall_result", 32'(result), 5);
        chk("stall_id", 32'(result_id), 1);
        cyc();
        chk("stall_done", 32'(result_valid), 0);
        $display("step stall total=%0d", result);

        // 5: saturation on ACC_W=4 instance: 5 x F -> 15
        req_s = 4'b0010; data_s = 16'h00F0; last_s = '0;
        cyc();
        chk("sat_gnt", 32'(gnt_s), 32'h2);
        for (int b = 0; b < 5; b++) begin
            last_s = (b == 4) ? 4'b0010 : 4'b0000;
            cyc();
        end
        req_s = '0; last_s = '0;
        chk("sat_valid", 32'(valid_s), 1);
        chk("sat_result", 32'(result_s), 15);
        chk("sat_id", 32'(id_s), 1);
        cyc();
        chk("sat_done", 32'(valid_s), 0);
        $display("step saturation total=%0d", result_s);

        // 6: reset mid-ACCUM after two F beats
        req = 4'b0010; data = 16'h00F0; last = '0;
        cyc();
        chk("mid_gnt", 32'(gnt), 32'h2);
        cycn(2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_valid", 32'(result_valid), 0);
        req = 4'b1111;
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("mid_rst_rr_gnt0", 32'(gnt), 32'h1);
        req = 4'b0001; last = 4'b0001; data = 16'h0000;
        cyc();
        req = '0; last = '0;
        chk("mid_clean_valid", 32'(result_valid), 1);
        chk("mid_clean_result", 32'(result), 0);
        cyc();
        $display("step reset mid-packet done");

        // Random phase: 3 packets per requester, random stalls/backpressure.
        // Reference: owners visit requesters with packets left in round-robin
        // order after the previous owner (requester 0 served last).
        for (int i = 0; i < 4; i++) begin
            for (int p = 0; p < 3; p++) begin
                nb[i][p] = $urandom_range(1, 6);
                for (int b = 0; b < 8; b++) pd[i][p][b] = 4'($urandom);
            end
            rem[i] = 3; used[i] = 0;
        end
        last_o = 0;
        for (int n = 0; n < 12; n++) begin
            c = -1;
            for (int k = 1; k <= 4; k++) begin
                if (c < 0 && rem[(last_o + k) % 4] > 0) c = (last_o + k) % 4;
            end
            s = 0;
            for (int b = 0; b < nb[c][used[c]]; b++) s += $countones(pd[c][used[c]][b]);
            if (s > 255) s = 255;
            eq_id.push_back(c);
            eq_sum.push_back(s);
            rem[c]--; used[c]++;
            last_o = c;
        end

        pk = '{0, 0, 0, 0};
        bt = '{0, 0, 0, 0};
        done_n = 0; cycles = 0;
        while (done_n < 12 && cycles < 3000) begin
            for (int i = 0; i < 4; i++) begin
                if (pk[i] < 3) begin
                    req[i] = !(gnt[i] && ($urandom_range(0, 3) == 0));
                    data[4*i +: 4] = pd[i][pk[i]][bt[i]];
                    last[i] = (bt[i] == nb[i][pk[i]] - 1);
                end else begin
                    req[i] = 1'b0;
                    data[4*i +: 4] = 4'bxxxx;
                end
                if (!req[i]) last[i] = 1'($urandom_range(0, 1));
            end
            result_ready = ($urandom_range(0, 9) < 7);
            if (result_valid && result_ready) begin
                if (eq_id.size() == 0) begin
                    chk("rand_spurious_result", 32'(result_valid), 0);
                end else begin
                    chk("rand_result", 32'(result), 32'(eq_sum[0]));
                    chk("rand_id", 32'(result_id), 32'(eq_id[0]));
                    $display("rand pkt id=%0d total=%0d", result_id, result);
                    void'(eq_id.pop_front());
                    void'(eq_sum.pop_front());
                    done_n++;
                end
            end
            chk("rand_gnt_onehot0", 32'($onehot0(gnt)), 1);
            g = gnt; r = req;
            cyc();
            cycles++;
            for (int i = 0; i < 4; i++) begin
                if (g[i] && r[i]) begin
                    if (bt[i] == nb[i][pk[i]] - 1) begin
                        chk("rand_valid_after_last", 32'(result_valid), 1);
                        pk[i]++;
                        bt[i] = 0;
                    end else begin
                        bt[i]++;
                    end
                end
            end
        end
        chk("rand_all_packets_done", 32'(done_n), 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
